uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one `uart_tx` between two byte-stream sources: the tokenizer output (port A) and an auxiliary message source such as a status or prompt generator (port B). It grants the transmitter to one source at a time and holds that grant for a whole packet, so the two streams never interleave on the wire. A packet ends on a terminator byte, a burst limit or an idle timeout. Sits between the tokenizer/message sources and `uart_tx`, in the same `i_divided_clk` domain.

## Interface
- `TERM`, 8'h0A: terminator byte; sending it ends the packet.
- `MAX_BURST`, 64: maximum bytes per grant (≥1).
- `IDLE_TIMEOUT`, 1024: consecutive cycles with the owner's ready low before the lock is released (≥1).

- `i_clk` in 1: the only clock (the divided UART clock).
- `i_rst` in 1: synchronous, active-high reset.
- `i_en` in 1: global enable; low freezes all state.
- `i_a_data` in 8: port A byte.
- `i_a_ready` in 1: port A byte valid.
- `o_a_next` out 1: one-cycle pulse; port A byte consumed.
- `i_b_data` in 8: port B byte.
- `i_b_ready` in 1: port B byte valid.
- `o_b_next` out 1: one-cycle pulse; port B byte consumed.
- `o_data` out 8: byte to `uart_tx.i_data`.
- `o_ready` out 1: to `uart_tx.i_ready`.
- `i_next` in 1: from `uart_tx.o_next`; one-cycle pulse, current byte consumed.
- `o_busy` out 1: a grant is held.
- `o_owner` out 1: current or last owner (0 = A, 1 = B).

## Operation
- **Registered state:**
  - `state` ∈ {IDLE, LOCK};
  - `owner`;
  - `last` (last served port);
  - `burst_cnt` [$clog2(MAX_BURST+1)];
  - `idle_cnt` [$clog2(IDLE_TIMEOUT+1)].
- **Reset** (synchronous, every cycle `i_rst`=1):
  - state=IDLE, owner=0, last=1 (so A wins the first tie), counters 0.
  - Outputs: o_ready=0, o_a_next=0, o_b_next=0, o_busy=0, o_owner=0, o_data=8'h00.
- **`i_en`=0:**
  - No state or counter change.
  - o_ready, o_a_next and o_b_next are forced to 0.
  - i_next is ignored.
- **IDLE:**
  - o_ready=0, o_busy=0.
  - If only one port has ready=1, grant that port.
  - If both ports have ready=1, grant the port ≠ `last` (round-robin).
  - On a grant: owner<=port, counters<=0, state<=LOCK.
  - If neither port is ready, stay in IDLE.
- **LOCK (combinational outputs):**
  - o_busy=1.
  - o_data = owner's data; o_ready = owner's ready & i_en.
  - o_x_next = i_next & o_ready, routed to the owner only.
  - The non-owner's next stays 0.
- **LOCK, consume** (i_next & o_ready):
  - burst_cnt += 1 and idle_cnt <= 0.
  - Release if o_data == TERM or burst_cnt+1 == MAX_BURST.
- **LOCK, idle counting:**
  - When the owner's ready=0 and no consume occurs, idle_cnt += 1.
  - Release when idle_cnt+1 == IDLE_TIMEOUT.
  - Owner ready=1 without a consume holds idle_cnt at 0.
- **Release:** state<=IDLE, last<=owner, counters<=0.
- **Spurious pulses:** an i_next while o_ready=0 (IDLE, or owner not ready) is ignored and not forwarded.
- **Simultaneous events:**
  - A consume and a timeout in the same cycle count as a consume (the idle counter resets).
  - A terminator byte and the burst limit on the same byte cause a single release.
- **Reset mid-packet:** the lock is dropped immediately. No next pulse is issued on the reset cycle, even if i_next is high.

## Timing
- **Grant latency:** a ready rising at cycle t in IDLE gives LOCK and o_ready=1 at t+1.
- **Data/ready path:** combinational through the mux, so `uart_tx` sees the owner's byte in the grant cycle.
- **Next path:** o_x_next is combinational from i_next, zero-cycle, one cycle wide.
- **After release:** the state is IDLE for at least one cycle (o_ready=0). The next grant is at the earliest 2 cycles after the releasing i_next.
- **Timeout release:** exactly IDLE_TIMEOUT cycles after the last consume or ready, given continuous owner ready=0 and i_en=1.
- **Cycles with i_en=0:** not counted.
- **Output sources:** o_busy and o_owner come directly from registers.

## Test plan
- **Single packet:**
  - Stimulus: A sends "ok\n" (8'h6F, 8'h6B, 8'h0A); uart_tx model pulses i_next 160 cycles apart.
  - Required: o_data follows the three bytes; o_a_next gets exactly 3 pulses; o_busy falls the cycle after the third pulse; o_owner=0.
- **No interleave:**
  - Stimulus: B raises ready mid-way through A's packet.
  - Required: no o_b_next until A's 8'h0A is consumed. B is granted 2 cycles after that pulse, and o_data switches to B's byte.
- **Round-robin:**
  - Stimulus: both ports hold ready continuously, each sending 1-byte packets of 8'h0A.
  - Required: the grant order is A, B, A, B; last toggles on each release.
- **Burst limit:**
  - Stimulus: MAX_BURST=4; A streams 10 non-terminator bytes while B is ready.
  - Required: A releases after 4 bytes, B gets the next grant, then A gets the one after.
- **Idle timeout and i_en freeze:**
  - Stimulus: IDLE_TIMEOUT=8; A sends 1 byte then drops ready; i_en is held low for 5 cycles in the middle.
  - Required: release 8 enabled cycles after the drop (13 wall cycles); o_ready=0 throughout the i_en=0 window.
- **Reset mid-packet:**
  - Stimulus: assert i_rst during A's second byte with i_next high.
  - Required: o_a_next=0 on that cycle; the next cycle shows o_busy=0, o_ready=0, o_owner=0. After reset, a tie between A and B is granted to A.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between two byte sources, holding the
// grant for a whole packet (ended by terminator, burst limit or idle timeout).
module uart_tx_arbiter #(
  parameter logic [7:0]  TERM         = 8'h0A,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_a_data,
  input  logic       i_a_ready,
  output logic       o_a_next,
  input  logic [7:0] i_b_data,
  input  logic       i_b_ready,
  output logic       o_b_next,
  output logic [7:0] o_data,
  output logic       o_ready,
  input  logic       i_next,
  output logic       o_busy,
  output logic       o_owner
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [7:0]    own_data;
  logic          own_ready;
  logic          consume;
  logic          rel;

  // Owner-side byte and valid selected by the current grant
  assign own_data  = owner_q ? i_b_data  : i_a_data;
  assign own_ready = owner_q ? i_b_ready : i_a_ready;

  // Grant/lock registers; everything frozen while disabled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      burst_q <= '0;
      idle_q  <= '0;
    end else if (i_en) begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

  // Next-state logic and the combinational mux/handshake towards uart_tx
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    burst_d  = burst_q;
    idle_d   = idle_q;
    o_data   = 8'h00;
    o_ready  = 1'b0;
    o_a_next = 1'b0;
    o_b_next = 1'b0;
    consume  = 1'b0;
    rel      = 1'b0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          if (i_en && (i_a_ready || i_b_ready)) begin
            state_d = LOCK;
            owner_d = (i_a_ready && i_b_ready) ? ~last_q : i_b_ready;
            burst_d = '0;
            idle_d  = '0;
          end
        end
        LOCK: begin
          o_data   = own_data;
          o_ready  = own_ready & i_en;
          consume  = i_next & own_ready & i_en;
          o_a_next = consume & ~owner_q;
          o_b_next = consume & owner_q;
          if (consume) begin
            burst_d = burst_q + BW'(1);
            idle_d  = '0;
            rel     = (own_data == TERM) || ((burst_q + BW'(1)) == BW'(MAX_BURST));
          end else if (i_en && !own_ready) begin
            idle_d = idle_q + IW'(1);
            rel    = (idle_q + IW'(1)) == IW'(IDLE_TIMEOUT);
          end else if (i_en) begin
            idle_d = '0;
          end
          if (rel) begin
            state_d = IDLE;
            last_d  = owner_q;
            burst_d = '0;
            idle_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status straight from the grant registers
  assign o_busy  = (state_q == LOCK);
  assign o_owner = owner_q;

endmodule
